pong_engine: RTL and testbench

//   Parametrised one-dimensional LED pong core. Replaces the fixed 16-LED light/clk_div pair.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/pong_tick_gen.sv | 28 ++
 rtl/pong_engine.sv | 211 +++++++++++++++++++++
 tb/tb_pong_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings for the one-dimensional LED pong core.
// Optional hit speed-up is enabled in pong_engine by defining PONG_SPEEDUP_EN.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'b00,
        ST_MOVE  = 2'b01,
        ST_POINT = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

    // Ball direction; player sides reuse the same encoding.
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/pong_tick_gen.sv
// pong_tick_gen: one-cycle game tick every TICK_DIV clocks.
// Counter restarts from zero on synchronous reset.
module pong_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/pong_engine.sv
// pong_engine: LED pong core - serve/rally/point/game-over sequencing and scores.
// Define PONG_SPEEDUP_EN to shorten the step period on every hit.
module pong_engine
    import pong_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int HIT_WIN     = 2,
    parameter int TICK_DIV    = 1_000_000,
    parameter int SPEED_INIT  = 20,
    parameter int SPEED_MIN   = 4,
    parameter int POINT_TICKS = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_l,
    input  logic               btn_r,
    output logic [WIDTH-1:0]   ball,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         state,
    output logic [1:0]         winner
);

    localparam int PW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SPD_MAX = (SPEED_INIT > SPEED_MIN) ? SPEED_INIT : SPEED_MIN;
    localparam int SW      = $clog2(SPD_MAX + 1);
    localparam int FW      = $clog2(POINT_TICKS + 1);

    localparam logic [PW-1:0]      POS_L  = '0;
    localparam logic [PW-1:0]      POS_R  = PW'(WIDTH - 1);
    localparam logic [PW-1:0]      HIT_L  = PW'(HIT_WIN);
    localparam logic [PW-1:0]      HIT_R  = PW'(WIDTH - HIT_WIN);
    localparam logic [SW-1:0]      P_INIT = SW'(SPEED_INIT);
    localparam logic [FW-1:0]      F_LAST = FW'(POINT_TICKS - 1);
    localparam logic [SCORE_W-1:0] S_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] S_MAX  = '1;
    localparam logic [WIDTH-1:0]   ONE    = WIDTH'(1);
`ifdef PONG_SPEEDUP_EN
    localparam logic [SW-1:0]      P_MIN  = SW'(SPEED_MIN);
`endif

    state_t             r_state, w_state;
    logic [PW-1:0]      r_pos, w_pos;
    logic               r_dir, w_dir;
    logic               r_server, w_server;
    logic               r_scorer, w_scorer;
    logic [SCORE_W-1:0] r_score_l, w_score_l;
    logic [SCORE_W-1:0] r_score_r, w_score_r;
    logic [1:0]         r_winner, w_winner;
    logic [SW-1:0]      r_period, w_period;
    logic [SW-1:0]      r_step, w_step_cnt;
    logic [FW-1:0]      r_flash, w_flash;
    logic               r_btn_l_q, r_btn_r_q;

    logic               w_tick;
    logic               w_press_l, w_press_r;
    logic               w_step, w_hit;
    logic               w_miss_l, w_miss_r;
    logic [SCORE_W-1:0] w_win_score;
    logic [PW-1:0]      w_serve_pos;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == S_MAX) ? s : s + 1'b1;
    endfunction

    pong_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_press_l = btn_l & ~r_btn_l_q;
    assign w_press_r = btn_r & ~r_btn_r_q;
    assign w_step    = w_tick && (r_step == r_period - 1'b1);

    assign w_hit = (w_press_l && r_dir == DIR_L && r_pos < HIT_L)
                || (w_press_r && r_dir == DIR_R && r_pos >= HIT_R);

    assign w_miss_l    = w_step && r_dir == DIR_L && r_pos == POS_L;
    assign w_miss_r    = w_step && r_dir == DIR_R && r_pos == POS_R;
    assign w_win_score = (r_scorer == DIR_L) ? r_score_l : r_score_r;
    assign w_serve_pos = (r_server == DIR_L) ? POS_L : POS_R;

    always_comb begin
        w_state    = r_state;
        w_pos      = r_pos;
        w_dir      = r_dir;
        w_server   = r_server;
        w_scorer   = r_scorer;
        w_score_l  = r_score_l;
        w_score_r  = r_score_r;
        w_winner   = r_winner;
        w_period   = r_period;
        w_step_cnt = r_step;
        w_flash    = r_flash;
        unique case (r_state)
            ST_SERVE: begin
                w_step_cnt = '0;
                w_period   = P_INIT;
                w_pos      = w_serve_pos;
                if (r_server == DIR_L && w_press_l) begin
                    w_state = ST_MOVE;
                    w_dir   = DIR_R;
                end else if (r_server == DIR_R && w_press_r) begin
                    w_state = ST_MOVE;
                    w_dir   = DIR_L;
                end
            end
            ST_MOVE: begin
                if (w_tick) begin
                    w_step_cnt = w_step ? '0 : r_step + 1'b1;
                end
                // A hit on the step cycle pre-empts the miss.
                if (w_hit) begin
                    w_dir      = ~r_dir;
                    w_step_cnt = '0;
`ifdef PONG_SPEEDUP_EN
                    w_period   = (r_period > P_MIN) ? r_period - 1'b1 : P_MIN;
`endif
                end else if (w_miss_l) begin
                    w_score_r = sat_inc(r_score_r);
                    w_scorer  = DIR_R;
                    w_server  = DIR_L;
                    w_state   = ST_POINT;
                    w_flash   = '0;
                end else if (w_miss_r) begin
                    w_score_l = sat_inc(r_score_l);
                    w_scorer  = DIR_L;
                    w_server  = DIR_R;
                    w_state   = ST_POINT;
                    w_flash   = '0;
                end else if (w_step) begin
                    w_pos = (r_dir == DIR_R) ? r_pos + 1'b1 : r_pos - 1'b1;
                end
            end
            ST_POINT: begin
                if (w_tick) begin
                    if (r_flash == F_LAST) begin
                        if (w_win_score == S_WIN) begin
                            w_state  = ST_OVER;
                            w_winner = (r_scorer == DIR_L) ? WIN_L : WIN_R;
                        end else begin
                            w_state    = ST_SERVE;
                            w_pos      = w_serve_pos;
                            w_period   = P_INIT;
                            w_step_cnt = '0;
                        end
                    end else begin
                        w_flash = r_flash + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (w_press_l || w_press_r) begin
                    w_score_l = '0;
                    w_score_r = '0;
                    w_winner  = WIN_NONE;
                    w_server  = DIR_L;
                    w_pos     = POS_L;
                    w_period  = P_INIT;
                    w_state   = ST_SERVE;
                end
            end
            default: begin
                w_state = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Loaded during reset too, so a held button never fires an edge.
        r_btn_l_q <= btn_l;
        r_btn_r_q <= btn_r;
        if (reset) begin
            r_state   <= ST_SERVE;
            r_pos     <= POS_L;
            r_dir     <= DIR_R;
            r_server  <= DIR_L;
            r_scorer  <= DIR_L;
            r_score_l <= '0;
            r_score_r <= '0;
            r_winner  <= WIN_NONE;
            r_period  <= P_INIT;
            r_step    <= '0;
            r_flash   <= '0;
        end else begin
            r_state   <= w_state;
            r_pos     <= w_pos;
            r_dir     <= w_dir;
            r_server  <= w_server;
            r_scorer  <= w_scorer;
            r_score_l <= w_score_l;
            r_score_r <= w_score_r;
            r_winner  <= w_winner;
            r_period  <= w_period;
            r_step    <= w_step_cnt;
            r_flash   <= w_flash;
        end
    end

    assign ball    = (r_state == ST_POINT || r_state == ST_OVER) ? '1 : ONE << r_pos;
    assign score_l = r_score_l;
    assign score_r = r_score_r;
    assign state   = r_state;
    assign winner  = r_winner;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: scoreboard bench for pong_engine (WIDTH=8, TICK_DIV=2, SPEED_INIT=3).
// Expected output snapshots and cycle spacings are queued by the stimulus, checked by a monitor.
module tb_pong_engine;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       btn_l = 1'b1;
    logic       btn_r = 1'b0;
    logic [7:0] ball;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] state;
    logic [1:0] winner;

    always #5 clk = ~clk;

    pong_engine #(
        .WIDTH       (8),
        .SCORE_W     (4),
        .WIN_SCORE   (2),
        .HIT_WIN     (2),
        .TICK_DIV    (2),
        .SPEED_INIT  (3),
        .SPEED_MIN   (1),
        .POINT_TICKS (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_l   (btn_l),
        .btn_r   (btn_r),
        .ball    (ball),
        .score_l (score_l),
        .score_r (score_r),
        .state   (state),
        .winner  (winner)
    );

`ifdef PONG_SPEEDUP_EN
    localparam int D3A = 4, D3B = 2, D4C = 4, D4D = 6, D4E = 2;
    localparam int D6F = 4, D6G = 2, T4W = 3;
`else
    localparam int D3A = 6, D3B = 6, D4C = 6, D4D = 12, D4E = 6;
    localparam int D6F = 6, D6G = 6, T4W = 5;
`endif

    logic [19:0] qv[$];
    int          qd[$];
    string       qn[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [3:0]  m_sl  = 4'd0;
    logic [3:0]  m_sr  = 4'd0;
    logic [1:0]  m_st  = 2'b00;
    logic [1:0]  m_win = 2'b00;

    task automatic push(input logic [7:0] b, input int dt, input string nm);
        qv.push_back({b, m_sl, m_sr, m_st, m_win});
        qd.push_back(dt);
        qn.push_back(nm);
    endtask

    task automatic push_run(input int from, input int to, input int dt, input string nm);
        int p = from;
        forever begin
            push(8'(1 << p), dt, nm);
            if (p == to) break;
            p += (to > from) ? 1 : -1;
        end
    endtask

    task automatic finish_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input bit right);
        if (right) btn_r = 1'b1;
        else btn_l = 1'b1;
        cyc(1);
        btn_l = 1'b0;
        btn_r = 1'b0;
    endtask

    task automatic wait_out(input logic [7:0] b, input logic [1:0] s, input string nm);
        int k = 0;
        while (!(ball === b && state === s)) begin
            if (k >= 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout %s: ball=%h state=%b, required ball=%h state=%b",
                         nm, ball, state, b, s);
                finish_up();
            end
            cyc(1);
            k++;
        end
    endtask

    initial begin : monitor
        logic [19:0] prev;
        logic [19:0] cur;
        logic [19:0] ev;
        int          ed;
        string       en;
        int          ncyc;
        int          last;
        prev = 'x;
        ncyc = 0;
        last = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!reset) begin
                cur = {ball, score_l, score_r, state, winner};
                if (cur !== prev) begin
                    prev = cur;
                    n_cmp++;
                    if (qv.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_change: got ball=%h sl=%0d sr=%0d st=%b win=%b, required no change",
                                 ball, score_l, score_r, state, winner);
                    end else begin
                        ev = qv.pop_front();
                        ed = qd.pop_front();
                        en = qn.pop_front();
                        if (cur !== ev || (ed != 0 && ncyc - last != ed)) begin
                            n_bad++;
                            $display("FAIL %s: got ball=%h sl=%0d sr=%0d st=%b win=%b dt=%0d, required ball=%h sl=%0d sr=%0d st=%b win=%b dt=%0d",
                                     en, ball, score_l, score_r, state, winner, ncyc - last,
                                     ev[19:12], ev[11:8], ev[7:4], ev[3:2], ev[1:0], ed);
                        end
                    end
                    last = ncyc;
                end
            end
        end
    end

    initial begin : stimulus
        int k;
        // 1: button held through reset, released, then a real serve.
        push(8'h01, 0, "reset_state");
        cyc(3);
        reset = 1'b0;
        cyc(3);
        btn_l = 1'b0;
        cyc(3);
        m_st = 2'b01;
        push(8'h01, 6, "t1_serve_press");
        // 2: unreturned serve from the left, point to the left.
        push(8'h02, 0, "t2_first_step");
        push_run(2, 7, 6, "t2_travel");
        m_sl = 4'd1;
        m_st = 2'b10;
        push(8'hFF, 6, "t2_point_flash");
        m_st = 2'b00;
        push(8'h80, 4, "t2_right_serves");
        press(1'b0);
        wait_out(8'h80, 2'b00, "t2_serve_r");

        // 3: hit at pos 1, ignored press at pos 3, point to the right.
        m_st = 2'b01;
        push(8'h80, 0, "t3_serve");
        push(8'h40, 0, "t3_first_step");
        push_run(5, 1, 6, "t3_left");
        push_run(2, 7, D3A, "t3_after_hit_l");
        push_run(6, 0, D3B, "t3_after_hit_r");
        m_sr = 4'd1;
        m_st = 2'b10;
        push(8'hFF, D3B, "t3_point");
        m_st = 2'b00;
        push(8'h01, 4, "t3_left_serves");
        press(1'b1);
        wait_out(8'h02, 2'b01, "t3_pos1");
        press(1'b0);
        wait_out(8'h80, 2'b01, "t3_pos7");
        press(1'b1);
        wait_out(8'h08, 2'b01, "t3_pos3");
        press(1'b0);
        wait_out(8'h01, 2'b00, "t3_serve_l");

        // 4: press on the exact step cycle at pos 0; 5: right wins the game.
        m_st = 2'b01;
        push(8'h01, 0, "t4_serve");
        push(8'h02, 0, "t4_first_step");
        push_run(2, 7, 6, "t4_right");
        push_run(6, 0, D4C, "t4_left");
        push(8'h02, D4D, "t4_hit_on_step");
        push_run(2, 7, D4E, "t4_right2");
        push_run(6, 0, D4E, "t5_left");
        m_sr = 4'd2;
        m_st = 2'b10;
        push(8'hFF, D4E, "t5_point");
        m_st  = 2'b11;
        m_win = 2'b10;
        push(8'hFF, 4, "t5_over");
        m_sl  = 4'd0;
        m_sr  = 4'd0;
        m_st  = 2'b00;
        m_win = 2'b00;
        push(8'h01, 0, "t5_restart");
        press(1'b0);
        wait_out(8'h80, 2'b01, "t4_pos7");
        press(1'b1);
        wait_out(8'h01, 2'b01, "t4_pos0");
        cyc(T4W);
        press(1'b0);
        wait_out(8'h80, 2'b01, "t5_pos7");
        press(1'b1);
        wait_out(8'hFF, 2'b11, "t5_over");
        press(1'b1);
        wait_out(8'h01, 2'b00, "t5_restart");

        // 6: three hits in a rally, then period back to initial at the next serve.
        m_st = 2'b01;
        push(8'h01, 0, "t6_serve");
        push(8'h02, 0, "t6_first_step");
        push_run(2, 7, 6, "t6_period3");
        push_run(6, 0, D6F, "t6_hit1");
        push_run(1, 7, D6G, "t6_hit2");
        push_run(6, 0, D6G, "t6_hit3");
        m_sr = 4'd1;
        m_st = 2'b10;
        push(8'hFF, D6G, "t6_point");
        m_st = 2'b00;
        push(8'h01, 4, "t6_serve_again");
        m_st = 2'b01;
        push(8'h01, 0, "t6_serve2");
        push(8'h02, 0, "t6_first_step2");
        push(8'h04, 6, "t6_period_restored");
        press(1'b0);
        wait_out(8'h80, 2'b01, "t6_pos7a");
        press(1'b1);
        wait_out(8'h01, 2'b01, "t6_pos0");
        press(1'b0);
        wait_out(8'h80, 2'b01, "t6_pos7b");
        press(1'b1);
        wait_out(8'h01, 2'b00, "t6_serve_l");
        press(1'b0);

        k = 0;
        while (qv.size() != 0 && k < 100) begin
            cyc(1);
            k++;
        end
        if (qv.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected changes never seen, required 0", qv.size());
        end
        finish_up();
    end

endmodule
